// File: rtl/int_seq.sv
// int_seq: interrupt / reset entry sequencer for the 65C02 core.
// Arbitrates RES, NMI, IRQ and BRK at instruction boundaries. It then owns the bus
// for the entry sequence: push PCH, PCL and P, fetch the vector, and reload PC.
// The core keeps its register file; this block only latches PC/P/S and issues strobes.
module int_seq (
    input  logic        PHI_0,
    input  logic        RST,
    input  logic        RES_N,
    input  logic        NMI_N,
    input  logic        IRQ_N,
    input  logic        RDY,
    input  logic        SYNC,
    input  logic        BRK,
    input  logic        I_FLAG,
    input  logic [15:0] PC,
    input  logic [7:0]  P,
    input  logic [7:0]  S,
    input  logic [7:0]  DB_IN,
    output logic [15:0] AB,
    output logic [7:0]  DB_OUT,
    output logic        RW,
    output logic        ACTIVE,
    output logic        S_DEC,
    output logic        SET_I,
    output logic        CLR_D,
    output logic        PC_LOAD,
    output logic [15:0] PC_NEW
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PCH  = 3'd1,
        ST_PCL  = 3'd2,
        ST_PSR  = 3'd3,
        ST_VLO  = 3'd4,
        ST_VHI  = 3'd5,
        ST_LOAD = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_RES = 2'd0,
        SRC_NMI = 2'd1,
        SRC_IRQ = 2'd2,
        SRC_BRK = 2'd3
    } src_t;

    state_t      state_q, state_d, fsm_next_s;
    src_t        src_q, src_d, start_src_s;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  p_q, p_d;
    logic [7:0]  s_q, s_d;
    logic [7:0]  vec_q, vec_d;      // low byte of the vector; the high byte is always FF
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic        res_pend_q, res_pend_d;
    logic        nmi_pend_q, nmi_pend_d;
    logic        nmi_prev_q;

    logic        nmi_edge_s;
    logic        nmi_clear_s;
    logic        irq_s;
    logic        start_s;
    logic [7:0]  s_m1_s;
    logic [7:0]  s_m2_s;
    logic [7:0]  psr_s;
    logic [15:0] vec_ab_s;

    assign nmi_edge_s = nmi_prev_q & ~NMI_N;
    assign irq_s      = ~IRQ_N & ~I_FLAG;
    assign s_m1_s     = s_q - 8'd1;
    assign s_m2_s     = s_q - 8'd2;
    assign psr_s      = {p_q[7:6], 1'b1, (src_q == SRC_BRK), p_q[3:0]};
    assign vec_ab_s   = {8'hFF, vec_q};

    // Start arbitration in IDLE: pending reset, then NMI, IRQ and BRK at a boundary.
    always_comb begin
        start_s     = 1'b0;
        start_src_s = SRC_RES;
        if (res_pend_q && RES_N) begin
            start_s     = 1'b1;
            start_src_s = SRC_RES;
        end else if (SYNC && nmi_pend_q) begin
            start_s     = 1'b1;
            start_src_s = SRC_NMI;
        end else if (SYNC && irq_s) begin
            start_s     = 1'b1;
            start_src_s = SRC_IRQ;
        end else if (SYNC && BRK) begin
            start_s     = 1'b1;
            start_src_s = SRC_BRK;
        end else begin
            start_s     = 1'b0;
            start_src_s = SRC_RES;
        end
    end

    // Next-state logic and latch updates; every step waits for RDY.
    always_comb begin
        fsm_next_s  = state_q;
        src_d       = src_q;
        pc_d        = pc_q;
        p_d         = p_q;
        s_d         = s_q;
        vec_d       = vec_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        nmi_clear_s = 1'b0;
        if (RDY) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_s) begin
                        fsm_next_s = ST_PCH;
                        src_d      = start_src_s;
                        pc_d       = PC;
                        p_d        = P;
                        s_d        = S;
                    end else begin
                        fsm_next_s = ST_IDLE;
                    end
                end
                ST_PCH: fsm_next_s = ST_PCL;
                ST_PCL: fsm_next_s = ST_PSR;
                ST_PSR: begin
                    fsm_next_s = ST_VLO;
                    // A pending NMI hijacks IRQ/BRK here; the pushed B bit stays as it was.
                    if (src_q == SRC_RES) begin
                        vec_d = 8'hFC;
                    end else if ((src_q == SRC_NMI) || nmi_pend_q) begin
                        vec_d       = 8'hFA;
                        nmi_clear_s = 1'b1;
                    end else begin
                        vec_d = 8'hFE;
                    end
                end
                ST_VLO: begin
                    fsm_next_s = ST_VHI;
                    lo_d       = DB_IN;
                end
                ST_VHI: begin
                    fsm_next_s = ST_LOAD;
                    hi_d       = DB_IN;
                end
                ST_LOAD: fsm_next_s = ST_IDLE;
                default: fsm_next_s = ST_IDLE;
            endcase
        end else begin
            fsm_next_s = state_q;
        end
    end

    // Reset pin aborts any sequence; pending flags merge their set and clear events.
    always_comb begin
        state_d    = RES_N ? fsm_next_s : ST_IDLE;
        res_pend_d = (!RES_N) ? 1'b1 :
                     ((state_q == ST_IDLE) && RDY && start_s && (start_src_s == SRC_RES)) ? 1'b0 :
                     res_pend_q;
        nmi_pend_d = nmi_edge_s ? 1'b1 :
                     (nmi_clear_s && RES_N) ? 1'b0 :
                     nmi_pend_q;
    end

    // State, latch and pending-flag registers.
    always_ff @(posedge PHI_0 or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            src_q      <= SRC_RES;
            pc_q       <= 16'h0000;
            p_q        <= 8'h00;
            s_q        <= 8'h00;
            vec_q      <= 8'hFC;
            lo_q       <= 8'h00;
            hi_q       <= 8'h00;
            res_pend_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            nmi_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            pc_q       <= pc_d;
            p_q        <= p_d;
            s_q        <= s_d;
            vec_q      <= vec_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            res_pend_q <= res_pend_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_prev_q <= NMI_N;
        end
    end

    // Moore output decode; strobes are qualified by RDY so stalls never repeat them.
    always_comb begin
        AB      = 16'h0000;
        DB_OUT  = 8'h00;
        RW      = 1'b1;
        ACTIVE  = (state_q != ST_IDLE) && RES_N;
        S_DEC   = 1'b0;
        SET_I   = 1'b0;
        CLR_D   = 1'b0;
        PC_LOAD = 1'b0;
        PC_NEW  = 16'h0000;
        case (state_q)
            ST_IDLE: begin
                AB = 16'h0000;
            end
            ST_PCH: begin
                AB     = {8'h01, s_q};
                DB_OUT = pc_q[15:8];
                RW     = (src_q == SRC_RES);
                S_DEC  = RDY;
            end
            ST_PCL: begin
                AB     = {8'h01, s_m1_s};
                DB_OUT = pc_q[7:0];
                RW     = (src_q == SRC_RES);
                S_DEC  = RDY;
            end
            ST_PSR: begin
                AB     = {8'h01, s_m2_s};
                DB_OUT = psr_s;
                RW     = (src_q == SRC_RES);
                S_DEC  = RDY;
            end
            ST_VLO: begin
                AB    = vec_ab_s;
                SET_I = RDY;
                CLR_D = RDY;
            end
            ST_VHI: begin
                AB = vec_ab_s + 16'd1;
            end
            ST_LOAD: begin
                PC_LOAD = RDY;
                PC_NEW  = {hi_q, lo_q};
            end
            default: begin
                AB = 16'h0000;
            end
        endcase
    end

endmodule
